// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin front end for a single-port RAM with
// asynchronous read. After reset it optionally zero-fills the whole RAM,
// then grants at most one request per cycle. Every accepted request
// produces a one-cycle response strobe on the following cycle.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  rq0_valid,
    output logic                  rq0_ready,
    input  logic                  rq0_write,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0] rq0_wdata,
    output logic                  rsp_0_valid,
    output logic [DATA_WIDTH-1:0] rsp_0_data,

    input  logic                  rq1_valid,
    output logic                  rq1_ready,
    input  logic                  rq1_write,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0] rq1_wdata,
    output logic                  rsp_1_valid,
    output logic [DATA_WIDTH-1:0] rsp_1_data,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy
);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    last_grant;   // index of the port granted most recently
    logic                    gnt0;
    logic                    gnt1;
    logic                    run;

    assign busy = (state == S_CLEAR);

    // Round-robin grant and memory-side multiplexing; rst_n gates every strobe
    always_comb begin
        run          = rst_n && (state == S_RUN);
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        mem_write_en = 1'b0;

        if (run) begin
            gnt0 = rq0_valid && (!rq1_valid || last_grant);
            gnt1 = rq1_valid && (!rq0_valid || !last_grant);
        end

        if (rst_n && (state == S_CLEAR)) begin
            mem_addr     = clr_cnt;
            mem_data_in  = '0;
            mem_write_en = 1'b1;
        end else if (gnt0) begin
            mem_addr     = rq0_addr;
            mem_data_in  = rq0_wdata;
            mem_write_en = rq0_write;
        end else if (gnt1) begin
            mem_addr     = rq1_addr;
            mem_data_in  = rq1_wdata;
            mem_write_en = rq1_write;
        end

        rq0_ready = gnt0;
        rq1_ready = gnt1;
    end

    // Clear sequencing, grant history and registered responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_cnt     <= '0;
            last_grant  <= 1'b1;
            rsp_0_valid <= 1'b0;
            rsp_0_data  <= '0;
            rsp_1_valid <= 1'b0;
            rsp_1_data  <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    rsp_0_valid <= 1'b0;
                    rsp_1_valid <= 1'b0;
                    clr_cnt     <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    rsp_0_valid <= gnt0;
                    rsp_1_valid <= gnt1;
                    if (gnt0) begin
                        last_grant <= 1'b0;
                        rsp_0_data <= rq0_write ? '0 : mem_data_out;
                    end
                    if (gnt1) begin
                        last_grant <= 1'b1;
                        rsp_1_data <= rq1_write ? '0 : mem_data_out;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an asynchronous-read RAM model.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rq0_valid, rq0_ready, rq0_write;
    logic [7:0] rq0_addr, rq0_wdata;
    logic       rsp_0_valid;
    logic [7:0] rsp_0_data;
    logic       rq1_valid, rq1_ready, rq1_write;
    logic [7:0] rq1_addr, rq1_wdata;
    logic       rsp_1_valid;
    logic [7:0] rsp_1_data;
    logic [7:0] mem_addr, mem_data_in, mem_data_out;
    logic       mem_write_en;
    logic       busy;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [7:0] ram [256];
    bit         ram_seeded = 1'b0;

    always #5 clk = ~clk;

    // RAM model: seeded with 0xAA so the clear has something to erase
    always @(posedge clk) begin
        if (!ram_seeded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'hAA;
            ram_seeded <= 1'b1;
        end else if (mem_write_en) begin
            ram[mem_addr] <= mem_data_in;
        end
    end
    assign mem_data_out = ram[mem_addr];

    mem_arbiter #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_write(rq0_write),
        .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rsp_0_valid(rsp_0_valid), .rsp_0_data(rsp_0_data),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_write(rq1_write),
        .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rsp_1_valid(rsp_1_valid), .rsp_1_data(rsp_1_data),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count clear cycles from the current point; checks sweep order and data
    task automatic run_clear(input string tag);
        int unsigned cnt = 0;
        int unsigned err = 0;
        while (busy && cnt < 300) begin
            if (mem_write_en !== 1'b1 || mem_addr !== cnt[7:0] || mem_data_in !== 8'h00) err++;
            tick();
            cnt++;
        end
        chk({tag, "_cycles"}, cnt, 256);
        chk({tag, "_sweep_err"}, err, 0);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        int unsigned r0, r1, nz, guard;
        logic        exp0;

        rst_n = 1'b0;
        rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 8'h01; rq0_wdata = 8'h11;
        rq1_valid = 1'b1; rq1_write = 1'b1; rq1_addr = 8'h02; rq1_wdata = 8'h22;

        // Reset state, with requests pending to show the gating
        tick(); tick();
        chk("rst_rq0_ready", rq0_ready, 0);
        chk("rst_rq1_ready", rq1_ready, 0);
        chk("rst_mem_we", mem_write_en, 0);
        chk("rst_rsp0_valid", rsp_0_valid, 0);
        chk("rst_rsp1_valid", rsp_1_valid, 0);
        chk("rst_rsp0_data", rsp_0_data, 0);
        chk("rst_rsp1_data", rsp_1_data, 0);
        chk("rst_busy", busy, 1);

        // Clear: 256 cycles of writes to addresses 0..255, requests ignored
        rst_n = 1'b1;
        #1;
        chk("clr_rq0_ready", rq0_ready, 0);
        run_clear("clear");
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        nz = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 8'h00) nz++;
        chk("clear_ram_nonzero", nz, 0);

        // Contention: both read continuously, grants alternate 0,1,...
        rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 8'hA5;
        rq1_valid = 1'b1; rq1_write = 1'b0; rq1_addr = 8'h5A;
        r0 = 0; r1 = 0;
        for (int i = 0; i < 6; i++) begin
            exp0 = (i % 2 == 0);
            #1;
            chk("cont_rq0_ready", rq0_ready, exp0);
            chk("cont_rq1_ready", rq1_ready, !exp0);
            tick();
            chk("cont_rsp0_valid", rsp_0_valid, exp0);
            chk("cont_rsp1_valid", rsp_1_valid, !exp0);
            r0 += rsp_0_valid; r1 += rsp_1_valid;
        end
        chk("cont_rsp0_count", r0, 3);
        chk("cont_rsp1_count", r1, 3);
        chk("cont_rsp0_data", rsp_0_data, 0);
        chk("cont_rsp1_data", rsp_1_data, 0);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        tick();

        // Single port: write 0x5A to 0x10 then read it back, back-to-back
        rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 8'h10; rq0_wdata = 8'h5A;
        #1;
        chk("wr_rq0_ready", rq0_ready, 1);
        chk("wr_mem_we", mem_write_en, 1);
        chk("wr_mem_addr", mem_addr, 8'h10);
        chk("wr_mem_din", mem_data_in, 8'h5A);
        tick();
        chk("wr_rsp0_valid", rsp_0_valid, 1);
        chk("wr_rsp0_data", rsp_0_data, 0);
        rq0_write = 1'b0;
        #1;
        chk("rd_rq0_ready", rq0_ready, 1);
        chk("rd_mem_we", mem_write_en, 0);
        tick();
        chk("rd_rsp0_valid", rsp_0_valid, 1);
        chk("rd_rsp0_data", rsp_0_data, 8'h5A);
        rq0_valid = 1'b0;
        #1;
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_din", mem_data_in, 0);
        tick();
        chk("rd_rsp0_pulse", rsp_0_valid, 0);
        chk("rd_rsp0_hold", rsp_0_data, 8'h5A);

        // Ordering: last grant was port 0, so port 1's write goes first
        rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 8'h7F;
        rq1_valid = 1'b1; rq1_write = 1'b1; rq1_addr = 8'h7F; rq1_wdata = 8'hC3;
        #1;
        chk("ord_rq1_ready", rq1_ready, 1);
        chk("ord_rq0_wait", rq0_ready, 0);
        chk("ord_mem_din", mem_data_in, 8'hC3);
        tick();
        rq1_valid = 1'b0;
        #1;
        chk("ord_rsp1_valid", rsp_1_valid, 1);
        chk("ord_rq0_ready", rq0_ready, 1);
        tick();
        rq0_valid = 1'b0;
        chk("ord_rsp0_valid", rsp_0_valid, 1);
        chk("ord_rsp0_data", rsp_0_data, 8'hC3);
        chk("ord_rsp1_pulse", rsp_1_valid, 0);

        // Wrap-around: top and bottom addresses stay distinct
        rq1_valid = 1'b1; rq1_write = 1'b1; rq1_addr = 8'hFF; rq1_wdata = 8'hFF;
        tick();
        rq1_addr = 8'h00; rq1_wdata = 8'h01;
        tick();
        rq1_write = 1'b0; rq1_addr = 8'hFF;
        tick();
        chk("wrap_rsp1_valid_ff", rsp_1_valid, 1);
        chk("wrap_rsp1_data_ff", rsp_1_data, 8'hFF);
        rq1_addr = 8'h00;
        tick();
        rq1_valid = 1'b0;
        chk("wrap_rsp1_valid_00", rsp_1_valid, 1);
        chk("wrap_rsp1_data_00", rsp_1_data, 8'h01);

        // Mid-transaction reset drops the pending response
        rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 8'h10;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", rq0_ready, 0);
        tick();
        rq0_valid = 1'b0;
        chk("mid_rst_rsp0_valid", rsp_0_valid, 0);
        chk("mid_rst_rsp0_data", rsp_0_data, 0);

        // Reset while clearing at 0x40 restarts the sweep from 0
        rst_n = 1'b1;
        guard = 0;
        #1;
        while (mem_addr !== 8'h40 && guard < 300) begin
            tick();
            guard++;
        end
        chk("clr2_reach_40", mem_addr, 8'h40);
        rst_n = 1'b0;
        #1;
        chk("clr2_rst_mem_we", mem_write_en, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("clr2_restart_addr", mem_addr, 0);
        run_clear("clear2");
        nz = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 8'h00) nz++;
        chk("clear2_ram_nonzero", nz, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
